// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: register-zero constant, ALU control codes,
// the control bundle (field order reused by the EX/MEM register) and the
// writeback-match helper used by the operand bypass.
package id_ex_pipe_reg_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // ALU control codes carried from decode to execute.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  // Control bundle, MSB first. Later pipeline registers keep this order.
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // True when the writeback stage is writing the register named by sel_reg.
  // Register $0 is hard-wired to zero, so it never matches.
  function automatic logic wb_match(input logic             wb_reg_wr,
                                    input logic [REG_W-1:0] wb_rd,
                                    input logic [REG_W-1:0] sel_reg);
    return wb_reg_wr && (wb_rd != REG_ZERO) && (wb_rd == sel_reg);
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_operand_bypass.sv
// Operand bypass: replaces an operand with the writeback data when the
// writeback stage is writing the register the operand was read from.
module operand_bypass #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        sel_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_reg_wr,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] out_data
);
  import id_ex_pipe_reg_pkg::*;

  // Select writeback data on a register match, otherwise pass the operand.
  always_comb begin
    out_data = in_data;
    if (wb_match(wb_reg_wr, wb_rd, sel_reg)) begin
      out_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. Loads decoded fields each cycle, holds on stall
// (refreshing held operands from writeback), inserts a zeroed bubble on
// flush, and keeps a saturating count of inserted bubbles.
module id_ex_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [DATA_W-1:0]   id_pc4,
  input  logic                id_reg_wr,
  input  logic                id_mem_rd,
  input  logic                id_mem_wr,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic                id_reg_dst,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                wb_reg_wr,
  input  logic [4:0]          wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_pc4,
  output logic                ex_reg_wr,
  output logic                ex_mem_rd,
  output logic                ex_mem_wr,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic                ex_reg_dst,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_valid,
  output logic [CNT_W-1:0]    bubble_cnt
);
  import id_ex_pipe_reg_pkg::*;

  ctrl_t              ctrl_d;
  ctrl_t              ctrl_q;
  logic [4:0]         rs_sel;
  logic [4:0]         rt_sel;
  logic [DATA_W-1:0]  rs_in;
  logic [DATA_W-1:0]  rt_in;
  logic [DATA_W-1:0]  rs_byp;
  logic [DATA_W-1:0]  rt_byp;

  assign ctrl_d = '{reg_wr:     id_reg_wr,
                    mem_rd:     id_mem_rd,
                    mem_wr:     id_mem_wr,
                    mem_to_reg: id_mem_to_reg,
                    alu_src:    id_alu_src,
                    reg_dst:    id_reg_dst};

  // One bypass per operand serves both paths: on a load it checks the
  // incoming register number, on a stall it checks the held one so a
  // multi-cycle hold never leaves a stale operand behind.
  assign rs_sel = stall ? ex_rs      : id_rs;
  assign rt_sel = stall ? ex_rt      : id_rt;
  assign rs_in  = stall ? ex_rs_data : id_rs_data;
  assign rt_in  = stall ? ex_rt_data : id_rt_data;

  operand_bypass #(.DATA_W(DATA_W)) u_rs_bypass (
    .sel_reg   (rs_sel),
    .in_data   (rs_in),
    .wb_reg_wr (wb_reg_wr),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_data  (rs_byp)
  );

  operand_bypass #(.DATA_W(DATA_W)) u_rt_bypass (
    .sel_reg   (rt_sel),
    .in_data   (rt_in),
    .wb_reg_wr (wb_reg_wr),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_data  (rt_byp)
  );

  // Pipeline fields: flush beats stall beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs      <= REG_ZERO;
      ex_rt      <= REG_ZERO;
      ex_rd      <= REG_ZERO;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ctrl_q     <= CTRL_NOP;
      ex_alu_op  <= '0;
      ex_valid   <= 1'b0;
    end else if (flush) begin
      ex_rs      <= REG_ZERO;
      ex_rt      <= REG_ZERO;
      ex_rd      <= REG_ZERO;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ctrl_q     <= CTRL_NOP;
      ex_alu_op  <= '0;
      ex_valid   <= 1'b0;
    end else if (stall) begin
      ex_rs_data <= rs_byp;
      ex_rt_data <= rt_byp;
    end else begin
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= rs_byp;
      ex_rt_data <= rt_byp;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      ctrl_q     <= ctrl_d;
      ex_alu_op  <= id_alu_op;
      ex_valid   <= 1'b1;
    end
  end

  // Bubble counter: one per flush edge, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (flush && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign ex_reg_wr     = ctrl_q.reg_wr;
  assign ex_mem_rd     = ctrl_q.mem_rd;
  assign ex_mem_wr     = ctrl_q.mem_wr;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;

endmodule
